fix_tx_serializer: RTL and testbench

FIX_TX_SERIALIZER -- requirements
Module: fix_tx_serializer

---
 rtl/fix_tx_serializer.sv | 353 +++++++++++++++++++++++++++++++++++
 tb/tb_fix_tx_serializer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fix_tx_serializer.sv
// -----------------------------------------------------------------------------
// fix_tx_serializer
//
// Purpose: serializes one FIX 4.2 message onto a byte stream with a
// valid/ready handshake:
//   "8=FIX.4.2<SOH>9=<len><SOH>{tag=value<SOH>}*10=<ccc><SOH>", SOH = 0x01.
// <len> is the minimal decimal form of the BodyLength given at start.
// <ccc> is the mod-256 byte sum of everything up to and including the SOH
// before "10=", written as three digits with leading zeros.
//
// Optional feature (macro FIX_TX_BODYLEN_CHECK_EN): counts the emitted body
// bytes and raises a sticky error_o when the count differs from the
// BodyLength given at start. When the macro is undefined, error_o is tied
// low and no counter is built.
//
// Ports:
//   clk            in   clock; all state updates on its rising edge
//   rst            in   asynchronous active-low reset
//   start_msg_i    in   begin a message (sampled only in IDLE)
//   body_len_i     in   [9:0] BodyLength, sampled with start_msg_i
//   field_valid_i  in   tag/value pair offered
//   field_ready_o  out  pair accepted when field_valid_i is also high
//   tag_i          in   [TAG_WIDTH-1:0] ASCII tag, byte 0 in [7:0] sent first
//   tag_len_i      in   [2:0] tag byte count (clamped to 1..4)
//   value_i        in   [VALUE_WIDTH-1:0] ASCII value, byte 0 sent first
//   value_len_i    in   [5:0] value byte count (clamped to 1..32)
//   last_field_i   in   accepted pair is the final body field
//   data_o         out  [7:0] serialized byte
//   data_valid_o   out  data_o valid
//   data_ready_i   in   downstream accepts the byte
//   busy_o         out  high in every state except IDLE
//   msg_done_o     out  pulse when the final SOH is accepted
//   error_o        out  sticky BodyLength mismatch flag
// -----------------------------------------------------------------------------
module fix_tx_serializer #(
  parameter int TAG_WIDTH   = 32,
  parameter int VALUE_WIDTH = 256
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_msg_i,
  input  logic [9:0]             body_len_i,
  input  logic                   field_valid_i,
  output logic                   field_ready_o,
  input  logic [TAG_WIDTH-1:0]   tag_i,
  input  logic [2:0]             tag_len_i,
  input  logic [VALUE_WIDTH-1:0] value_i,
  input  logic [5:0]             value_len_i,
  input  logic                   last_field_i,
  output logic [7:0]             data_o,
  output logic                   data_valid_o,
  input  logic                   data_ready_i,
  output logic                   busy_o,
  output logic                   msg_done_o,
  output logic                   error_o
);

  localparam int         TAG_BYTES = TAG_WIDTH / 8;
  localparam int         VAL_BYTES = VALUE_WIDTH / 8;
  localparam int         TIW       = $clog2(TAG_BYTES);
  localparam int         VIW       = $clog2(VAL_BYTES);
  localparam logic [2:0] TAG_MAX   = 3'(TAG_BYTES);
  localparam logic [5:0] VAL_MAX   = 6'(VAL_BYTES);
  localparam logic [7:0] SOH       = 8'h01;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_BEGIN,
    ST_BLEN,
    ST_FIELD_WAIT,
    ST_TAG,
    ST_EQ,
    ST_VALUE,
    ST_FSOH,
    ST_CKHDR,
    ST_CKDIG,
    ST_CKSOH
  } state_t;

  state_t                 state_q, state_d;
  logic [5:0]             idx_q, idx_d;       // byte index inside the current state
  logic [9:0]             blen_q, blen_d;
  logic [1:0]             ndig_q, ndig_d;     // number of BodyLength digits, 1..3
  logic [TAG_WIDTH-1:0]   tag_q, tag_d;
  logic [2:0]             tag_len_q, tag_len_d;
  logic [VALUE_WIDTH-1:0] val_q, val_d;
  logic [5:0]             val_len_q, val_len_d;
  logic                   last_q, last_d;
  logic [7:0]             cksum_q, cksum_d;

  logic       accept;
  logic [9:0] blen_in;
  logic [1:0] dpos;
  logic [7:0] len_h, len_t, len_o;
  logic [7:0] ck_h, ck_t, ck_o;

  // Byte views of the latched tag and value.
  logic [7:0] tag_byte [TAG_BYTES];
  logic [7:0] val_byte [VAL_BYTES];

  for (genvar gi = 0; gi < TAG_BYTES; gi++) begin : g_tag_bytes
    assign tag_byte[gi] = tag_q[8*gi +: 8];
  end

  for (genvar gi = 0; gi < VAL_BYTES; gi++) begin : g_val_bytes
    assign val_byte[gi] = val_q[8*gi +: 8];
  end

  // BodyLength beyond three digits cannot be printed; pin it to 999.
  assign blen_in = (body_len_i > 10'd999) ? 10'd999 : body_len_i;

  assign len_h = 8'h30 + 8'(blen_q / 10'd100);
  assign len_t = 8'h30 + 8'((blen_q / 10'd10) % 10'd10);
  assign len_o = 8'h30 + 8'(blen_q % 10'd10);

  assign ck_h = 8'h30 + (cksum_q / 8'd100);
  assign ck_t = 8'h30 + ((cksum_q / 8'd10) % 8'd10);
  assign ck_o = 8'h30 + (cksum_q % 8'd10);

  assign busy_o = (state_q != ST_IDLE);

  function automatic logic [7:0] hdr_byte(input logic [3:0] i);
    logic [7:0] b;
    case (i)
      4'd0:    b = "8";
      4'd1:    b = "=";
      4'd2:    b = "F";
      4'd3:    b = "I";
      4'd4:    b = "X";
      4'd5:    b = ".";
      4'd6:    b = "4";
      4'd7:    b = ".";
      4'd8:    b = "2";
      4'd9:    b = SOH;
      4'd10:   b = "9";
      default: b = "=";
    endcase
    return b;
  endfunction

  function automatic logic [7:0] pick3(input logic [1:0] sel, input logic [7:0] d0,
                                       input logic [7:0] d1, input logic [7:0] d2);
    logic [7:0] b;
    case (sel)
      2'd0:    b = d0;
      2'd1:    b = d1;
      default: b = d2;
    endcase
    return b;
  endfunction

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    blen_d        = blen_q;
    ndig_d        = ndig_q;
    tag_d         = tag_q;
    tag_len_d     = tag_len_q;
    val_d         = val_q;
    val_len_d     = val_len_q;
    last_d        = last_q;
    cksum_d       = cksum_q;
    data_o        = 8'h00;
    data_valid_o  = 1'b1;
    field_ready_o = 1'b0;
    msg_done_o    = 1'b0;
    // Short lengths skip the leading digit positions (hundreds, tens).
    dpos          = idx_q[1:0] + (2'd3 - ndig_q);

    // Output byte is a pure function of registered state, so it holds
    // steady for as long as the downstream stalls.
    case (state_q)
      ST_IDLE:       data_valid_o = 1'b0;
      ST_BEGIN:      data_o = hdr_byte(idx_q[3:0]);
      ST_BLEN:       data_o = (idx_q[1:0] == ndig_q) ? SOH : pick3(dpos, len_h, len_t, len_o);
      ST_FIELD_WAIT: begin
        data_valid_o  = 1'b0;
        field_ready_o = 1'b1;
      end
      ST_TAG:        data_o = tag_byte[idx_q[TIW-1:0]];
      ST_EQ:         data_o = "=";
      ST_VALUE:      data_o = val_byte[idx_q[VIW-1:0]];
      ST_FSOH:       data_o = SOH;
      ST_CKHDR:      data_o = pick3(idx_q[1:0], "1", "0", "=");
      ST_CKDIG:      data_o = pick3(idx_q[1:0], ck_h, ck_t, ck_o);
      ST_CKSOH:      data_o = SOH;
      default:       data_valid_o = 1'b0;
    endcase

    accept = data_valid_o && data_ready_i;

    // Everything before "10=" contributes to the checksum.
    if (accept && !(state_q inside {ST_CKHDR, ST_CKDIG, ST_CKSOH})) begin
      cksum_d = cksum_q + data_o;
    end

    case (state_q)
      ST_IDLE: begin
        if (start_msg_i) begin
          state_d = ST_BEGIN;
          idx_d   = 6'd0;
          cksum_d = 8'h00;
          blen_d  = blen_in;
          ndig_d  = (blen_in >= 10'd100) ? 2'd3 : (blen_in >= 10'd10) ? 2'd2 : 2'd1;
        end
      end
      ST_BEGIN: begin
        if (accept) begin
          if (idx_q == 6'd11) begin
            state_d = ST_BLEN;
            idx_d   = 6'd0;
          end else begin
            idx_d = idx_q + 6'd1;
          end
        end
      end
      ST_BLEN: begin
        if (accept) begin
          if (idx_q[1:0] == ndig_q) begin
            state_d = ST_FIELD_WAIT;
            idx_d   = 6'd0;
          end else begin
            idx_d = idx_q + 6'd1;
          end
        end
      end
      ST_FIELD_WAIT: begin
        if (field_valid_i) begin
          state_d   = ST_TAG;
          idx_d     = 6'd0;
          tag_d     = tag_i;
          val_d     = value_i;
          last_d    = last_field_i;
          tag_len_d = (tag_len_i == 3'd0) ? 3'd1 : (tag_len_i > TAG_MAX) ? TAG_MAX : tag_len_i;
          val_len_d = (value_len_i == 6'd0) ? 6'd1 :
                      (value_len_i > VAL_MAX) ? VAL_MAX : value_len_i;
        end
      end
      ST_TAG: begin
        if (accept) begin
          if (idx_q == ({3'b000, tag_len_q} - 6'd1)) begin
            state_d = ST_EQ;
            idx_d   = 6'd0;
          end else begin
            idx_d = idx_q + 6'd1;
          end
        end
      end
      ST_EQ: begin
        if (accept) begin
          state_d = ST_VALUE;
          idx_d   = 6'd0;
        end
      end
      ST_VALUE: begin
        if (accept) begin
          if (idx_q == (val_len_q - 6'd1)) begin
            state_d = ST_FSOH;
            idx_d   = 6'd0;
          end else begin
            idx_d = idx_q + 6'd1;
          end
        end
      end
      ST_FSOH: begin
        if (accept) begin
          state_d = last_q ? ST_CKHDR : ST_FIELD_WAIT;
          idx_d   = 6'd0;
        end
      end
      ST_CKHDR, ST_CKDIG: begin
        if (accept) begin
          if (idx_q == 6'd2) begin
            state_d = (state_q == ST_CKHDR) ? ST_CKDIG : ST_CKSOH;
            idx_d   = 6'd0;
          end else begin
            idx_d = idx_q + 6'd1;
          end
        end
      end
      ST_CKSOH: begin
        if (accept) begin
          state_d    = ST_IDLE;
          msg_done_o = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= 6'd0;
      blen_q    <= 10'd0;
      ndig_q    <= 2'd1;
      tag_q     <= '0;
      tag_len_q <= 3'd1;
      val_q     <= '0;
      val_len_q <= 6'd1;
      last_q    <= 1'b0;
      cksum_q   <= 8'h00;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      blen_q    <= blen_d;
      ndig_q    <= ndig_d;
      tag_q     <= tag_d;
      tag_len_q <= tag_len_d;
      val_q     <= val_d;
      val_len_q <= val_len_d;
      last_q    <= last_d;
      cksum_q   <= cksum_d;
    end
  end

`ifdef FIX_TX_BODYLEN_CHECK_EN
  logic [9:0] bcnt_q, bcnt_d;
  logic       err_q, err_d;

  always_comb begin
    bcnt_d = bcnt_q;
    err_d  = err_q;
    if (state_q == ST_IDLE && start_msg_i) begin
      bcnt_d = 10'd0;
      err_d  = 1'b0;
    end else if (accept && (state_q inside {ST_TAG, ST_EQ, ST_VALUE, ST_FSOH})) begin
      if (bcnt_q != 10'h3FF) begin
        bcnt_d = bcnt_q + 10'd1;
      end
      // The final field SOH is being counted this cycle, hence the +1.
      if (state_q == ST_FSOH && last_q && ((bcnt_q + 10'd1) != blen_q)) begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bcnt_q <= 10'd0;
      err_q  <= 1'b0;
    end else begin
      bcnt_q <= bcnt_d;
      err_q  <= err_d;
    end
  end

  assign error_o = err_q;
`else
  assign error_o = 1'b0;
`endif

endmodule

// File: tb/tb_fix_tx_serializer.sv
// -----------------------------------------------------------------------------
// tb_fix_tx_serializer
//
// Directed bench for fix_tx_serializer. Each message is driven by run_msg,
// which captures accepted bytes as a printable string ('|' stands for SOH)
// and compares it against hand-written expected text.
// -----------------------------------------------------------------------------
module tb_fix_tx_serializer;

  logic         clk = 1'b0;
  logic         rst;
  logic         start_msg_i;
  logic [9:0]   body_len_i;
  logic         field_valid_i;
  logic         field_ready_o;
  logic [31:0]  tag_i;
  logic [2:0]   tag_len_i;
  logic [255:0] value_i;
  logic [5:0]   value_len_i;
  logic         last_field_i;
  logic [7:0]   data_o;
  logic         data_valid_o;
  logic         data_ready_i;
  logic         busy_o;
  logic         msg_done_o;
  logic         error_o;

  always #5 clk = ~clk;

  fix_tx_serializer #(
    .TAG_WIDTH  (32),
    .VALUE_WIDTH(256)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start_msg_i  (start_msg_i),
    .body_len_i   (body_len_i),
    .field_valid_i(field_valid_i),
    .field_ready_o(field_ready_o),
    .tag_i        (tag_i),
    .tag_len_i    (tag_len_i),
    .value_i      (value_i),
    .value_len_i  (value_len_i),
    .last_field_i (last_field_i),
    .data_o       (data_o),
    .data_valid_o (data_valid_o),
    .data_ready_i (data_ready_i),
    .busy_o       (busy_o),
    .msg_done_o   (msg_done_o),
    .error_o      (error_o)
  );

`ifdef FIX_TX_BODYLEN_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  int checks   = 0;
  int failures = 0;

  // Field table consumed by run_msg.
  logic [31:0]  f_tag  [4];
  logic [2:0]   f_tlen [4];
  logic [255:0] f_val  [4];
  logic [5:0]   f_vlen [4];
  logic         f_last [4];

  // Per-message observations.
  string      got;
  int         done_cnt, stall_bad, idle_cyc, nacc;
  logic       timeout, first_valid, err_before, err_at, err_after_start;
  logic [7:0] first_byte;
  int         err_probe_pos = 19;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
    end
  endtask

  task automatic chk_str(input string name, input string obs, input string exp);
    checks++;
    assert (obs == exp) else begin
      failures++;
      $error("FAIL %s observed=%s expected=%s", name, obs, exp);
    end
  endtask

  function automatic string pch(input logic [7:0] b);
    if (b == 8'h01) return "|";
    if (b < 8'h20 || b > 8'h7E) return "?";
    return $sformatf("%c", b);
  endfunction

  function automatic logic [255:0] pack(input string s);
    logic [255:0] v = '0;
    for (int i = 0; i < s.len() && i < 32; i++) v[8*i +: 8] = s[i];
    return v;
  endfunction

  // Appends "10=ccc|" to a printable stream, treating '|' as SOH (0x01).
  function automatic string with_ck(input string s);
    int sum = 0;
    for (int i = 0; i < s.len(); i++) sum += (s[i] == 8'h7C) ? 1 : int'(s[i]);
    return {s, $sformatf("10=%03d|", sum % 256)};
  endfunction

  task automatic set_field(input int i, input string t, input logic [2:0] tl,
                           input string v, input logic [5:0] vl, input logic last);
    logic [255:0] tp;
    tp        = pack(t);
    f_tag[i]  = tp[31:0];
    f_tlen[i] = tl;
    f_val[i]  = pack(v);
    f_vlen[i] = vl;
    f_last[i] = last;
  endtask

  // Starts a message at the current negedge and drives it to msg_done_o
  // (or until abort_after bytes have been seen accepted).
  task automatic run_msg(input string name, input logic [9:0] blen, input int nf,
                         input bit bp, input int abort_after);
    int         fidx = 0;
    int         cyc  = 0;
    bit         stalled = 1'b0;
    bit         done = 1'b0;
    logic [7:0] held = 8'h00;
    got = ""; done_cnt = 0; stall_bad = 0; idle_cyc = 0; nacc = 0; timeout = 1'b0;
    err_before = 1'bx; err_at = 1'bx;
    start_msg_i  = 1'b1;
    body_len_i   = blen;
    data_ready_i = 1'b1;
    @(negedge clk);
    start_msg_i = 1'b0;
    while (!done) begin
      if (cyc >= 1000) begin
        timeout = 1'b1;
        break;
      end
      data_ready_i  = bp ? (cyc % 2 == 0) : 1'b1;
      field_valid_i = (fidx < nf);
      if (fidx < nf) begin
        tag_i        = f_tag[fidx];
        tag_len_i    = f_tlen[fidx];
        value_i      = f_val[fidx];
        value_len_i  = f_vlen[fidx];
        last_field_i = f_last[fidx];
      end
      #1;
      if (cyc == 0) begin
        first_valid     = data_valid_o;
        first_byte      = data_o;
        err_after_start = error_o;
      end
      if (stalled && (!data_valid_o || data_o !== held)) stall_bad++;
      stalled = data_valid_o && !data_ready_i;
      held    = data_o;
      if (!data_valid_o) idle_cyc++;
      if (data_valid_o && got.len() == err_probe_pos - 1) err_before = error_o;
      if (data_valid_o && got.len() == err_probe_pos) err_at = error_o;
      if (data_valid_o && data_ready_i) begin
        got = {got, pch(data_o)};
        nacc++;
      end
      if (msg_done_o) begin
        done_cnt++;
        done = 1'b1;
      end
      if (field_ready_o && field_valid_i) fidx++;
      if (abort_after > 0 && nacc == abort_after) break;
      @(negedge clk);
      cyc++;
    end
    field_valid_i = 1'b0;
    $display("msg %s: %0d bytes \"%s\" done_pulses=%0d", name, got.len(), got, done_cnt);
  endtask

  initial begin
    rst = 1'b1; start_msg_i = 1'b0; body_len_i = '0; field_valid_i = 1'b0;
    tag_i = '0; tag_len_i = '0; value_i = '0; value_len_i = '0; last_field_i = 1'b0;
    data_ready_i = 1'b1;
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_data", data_o, 8'h00);
    chk("rst_valid", data_valid_o, 1'b0);
    chk("rst_fready", field_ready_o, 1'b0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_done", msg_done_o, 1'b0);
    chk("rst_error", error_o, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Basic single-field message.
    set_field(0, "35", 3'd2, "A", 6'd1, 1'b1);
    run_msg("basic", 10'd5, 1, 1'b0, 0);
    chk("basic_first_valid", first_valid, 1'b1);
    chk("basic_first_byte", first_byte, 8'h38);
    chk_str("basic_stream", got, "8=FIX.4.2|9=5|35=A|10=178|");
    chk("basic_done_pulses", done_cnt, 1);
    chk("basic_timeout", timeout, 1'b0);
    chk("basic_err_at_ck", err_at, 1'b0);
    #1;
    chk("basic_busy_after", busy_o, 1'b0);
    @(negedge clk);

    // Same message with data_ready_i toggling.
    run_msg("backpressure", 10'd5, 1, 1'b1, 0);
    chk_str("bp_stream", got, "8=FIX.4.2|9=5|35=A|10=178|");
    chk("bp_stall_unstable", stall_bad, 0);
    chk("bp_done_pulses", done_cnt, 1);
    chk("bp_timeout", timeout, 1'b0);

    // Two fields; FIELD_WAIT must last a single cycle per offered field.
    set_field(0, "35", 3'd2, "D", 6'd1, 1'b0);
    set_field(1, "11", 3'd2, "ABCD", 6'd4, 1'b1);
    run_msg("multi", 10'd12, 2, 1'b0, 0);
    chk_str("multi_stream", got, "8=FIX.4.2|9=12|35=D|11=ABCD|10=141|");
    chk("multi_idle_cycles", idle_cyc, 2);
    chk("multi_done_pulses", done_cnt, 1);

    // Clamps: tag_len 0->1, value_len 40->32, tag_len 7->4, value_len 0->1; "9=0".
    set_field(0, "58", 3'd0, "abcdefghijklmnopqrstuvwxyzABCDEF", 6'd40, 1'b0);
    set_field(1, "1234", 3'd7, "Z", 6'd0, 1'b1);
    run_msg("clamp", 10'd0, 2, 1'b0, 0);
    chk_str("clamp_stream", got,
            with_ck("8=FIX.4.2|9=0|5=abcdefghijklmnopqrstuvwxyzABCDEF|1234=Z|"));
    chk("clamp_done_pulses", done_cnt, 1);
    @(negedge clk);

    // Three-digit BodyLength, checksum with a leading zero.
    set_field(0, "35", 3'd2, "A", 6'd1, 1'b1);
    run_msg("len999", 10'd999, 1, 1'b0, 0);
    chk_str("len999_stream", got, "8=FIX.4.2|9=999|35=A|10=040|");
    @(negedge clk);

    // Reset in the middle of the value bytes, then a clean restart.
    set_field(0, "35", 3'd2, "ABCDEFGHIJ", 6'd10, 1'b1);
    run_msg("abort", 10'd5, 1, 1'b0, 20);
    chk_str("abort_partial", got, "8=FIX.4.2|9=5|35=ABC");
    #2 rst = 1'b0;
    #1;
    chk("abort_data", data_o, 8'h00);
    chk("abort_valid", data_valid_o, 1'b0);
    chk("abort_busy", busy_o, 1'b0);
    chk("abort_fready", field_ready_o, 1'b0);
    chk("abort_done", msg_done_o, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    set_field(0, "35", 3'd2, "A", 6'd1, 1'b1);
    run_msg("restart", 10'd5, 1, 1'b0, 0);
    chk_str("restart_stream", got, "8=FIX.4.2|9=5|35=A|10=178|");
    chk("restart_done_pulses", done_cnt, 1);
    @(negedge clk);

    // BodyLength mismatch (5 body bytes, 6 declared).
    run_msg("mismatch", 10'd6, 1, 1'b0, 0);
    chk_str("mismatch_stream", got, "8=FIX.4.2|9=6|35=A|10=179|");
    chk("mismatch_err_before_soh", err_before, 1'b0);
    chk("mismatch_err_at_ck", err_at, EXP_ERR);
    #1;
    chk("mismatch_err_sticky", error_o, EXP_ERR);
    @(negedge clk);
    run_msg("after_mismatch", 10'd5, 1, 1'b0, 0);
    chk("err_cleared_by_start", err_after_start, 1'b0);
    chk_str("after_mismatch_stream", got, "8=FIX.4.2|9=5|35=A|10=178|");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
